// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order word fetches to instruction memory and
// buffers returned {pc, word} pairs for decode; redirects flush and mark in-flight fetches stale.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIM  = (CW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_pc_q   [DEPTH];
    logic [31:0]   r_word_q [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;

    // credit covers both buffered and in-flight words, so a response always has a free slot
    assign w_target       = redirect_pc & ~32'h3;
    assign imem_req_valid = !rst && !redirect_valid && (({1'b0, r_count} + {1'b0, r_out}) < LIM);
    assign imem_req_addr  = r_fetch_pc;
    assign w_acc          = imem_req_valid && imem_req_ready;
    assign w_push         = imem_resp_valid && !redirect_valid && (r_drop == '0);
    assign inst_valid     = (r_count != '0);
    assign w_pop          = inst_valid && inst_ready && !redirect_valid;
    assign inst           = r_word_q[r_head];
    assign inst_pc        = r_pc_q[r_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_q[i]   <= '0;
                r_word_q[i] <= '0;
            end
        end else begin
            r_out <= r_out + CW'(w_acc) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // every fetch still in flight after this cycle belongs to the old path
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_drop     <= r_out - CW'(imem_resp_valid);
            end else begin
                if (w_acc) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) begin
                    r_pc_q[r_tail]   <= r_resp_pc;
                    r_word_q[r_tail] <= imem_resp_data;
                    r_tail           <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
                    r_resp_pc        <= r_resp_pc + 32'd4;
                end
                if (w_pop) r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
                if (imem_resp_valid && r_drop != '0) r_drop <= r_drop - 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: in-order memory model plus a scoreboard of expected {pc, word} entries,
// a per-cycle vector table for the startup sequence and directed redirect/reset sequences.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {logic [31:0] addr; int due; int ep;} mreq_t;
    typedef struct {logic [31:0] pc; logic [31:0] word;} ent_t;
    typedef struct {logic rr; logic ir; logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc;} vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic        redirect_valid, inst_valid, inst_ready;
    logic [31:0] redirect_pc, inst, inst_pc;
    logic        d2_req_valid, d2_inst_valid;
    logic [31:0] d2_req_addr, d2_inst, d2_inst_pc;
    logic        d2_hi = 1'b1;
    logic        d2_lo = 1'b0;
    logic [31:0] d2_zero = 32'h0;

    mreq_t       mq[$];
    ent_t        sb[$];
    vec_t        tbl[7];
    logic [31:0] d2_addr[4];
    int          cyc, lat, ep, checks, fails, n_acc;
    logic [31:0] exp_fetch, last_acc, pc;
    logic        found;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(d2_req_valid), .imem_req_ready(d2_hi), .imem_req_addr(d2_req_addr),
        .imem_resp_valid(d2_lo), .imem_resp_data(d2_zero),
        .redirect_valid(d2_lo), .redirect_pc(d2_zero),
        .inst_valid(d2_inst_valid), .inst_ready(d2_hi), .inst(d2_inst), .inst_pc(d2_inst_pc)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a ^ 32'h5A3C_00F1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // negedge half of a cycle: compare outputs against the model, then advance the model
    task automatic half();
        logic  acc, exp_rv;
        logic [31:0] acc_addr;
        mreq_t m;
        ent_t  e;
        @(negedge clk);
        exp_rv = !redirect_valid && (sb.size() + mq.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        acc = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (acc) chk("req_addr", imem_req_addr, exp_fetch);
        chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
        if (inst_valid && sb.size() != 0) begin
            chk("inst_pc", inst_pc, sb[0].pc);
            chk("inst_word", inst, sb[0].word);
            if (inst_ready && !redirect_valid) e = sb.pop_front();
        end
        checks++;
        if (dut.r_drop > dut.r_out || int'(dut.r_count) + int'(dut.r_out) > DEPTH || (imem_resp_valid && dut.r_out == '0)) begin
            fails++;
            $display("FAIL invariant: count=%0d outstanding=%0d drop=%0d resp=%0b (cycle %0d)",
                     dut.r_count, dut.r_out, dut.r_drop, imem_resp_valid, cyc);
        end
        if (imem_resp_valid && mq.size() != 0) begin
            m = mq.pop_front();
            if (!redirect_valid && m.ep == ep) sb.push_back('{m.addr, word_of(m.addr)});
        end
        if (redirect_valid) begin
            sb.delete();
            ep++;
            exp_fetch = redirect_pc & ~32'h3;
        end else if (acc) exp_fetch += 32'd4;
        if (acc) begin
            mq.push_back('{acc_addr, cyc + lat, ep});
            n_acc++;
            last_acc = acc_addr;
        end
    endtask

    task automatic tail();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        imem_resp_valid = (mq.size() != 0) && (mq[0].due <= cyc);
        imem_resp_data = imem_resp_valid ? word_of(mq[0].addr) : 32'hDEAD_BEEF;
    endtask

    task automatic step();
        half();
        tail();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        mq.delete();
        sb.delete();
        exp_fetch = RESET_PC;
        n_acc = 0;
    endtask

    task automatic wait_iv(input int bound, output logic f, output logic [31:0] p);
        f = 1'b0;
        p = 32'h0;
        for (int i = 0; i < bound && !f; i++) begin
            half();
            if (inst_valid) begin
                f = 1'b1;
                p = inst_pc;
            end
            tail();
        end
    endtask

    task automatic wait_acc(input int bound, output logic f, output logic [31:0] p);
        f = 1'b0;
        p = 32'h0;
        for (int i = 0; i < bound && !f; i++) begin
            half();
            if (imem_req_valid && imem_req_ready) begin
                f = 1'b1;
                p = imem_req_addr;
            end
            tail();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        checks = 0; fails = 0; lat = 1; ep = 0; cyc = 0; n_acc = 0;
        exp_fetch = RESET_PC; last_acc = 32'h0;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        d2_addr[0] = 32'hFFFF_FFF8; d2_addr[1] = 32'hFFFF_FFFC;
        d2_addr[2] = 32'h0000_0000; d2_addr[3] = 32'h0000_0004;
        @(posedge clk);
        #1;
        do_reset();
        // startup stream on dut; dut2 shows the wrap from a high RESET_PC
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            imem_req_ready = tbl[i].rr;
            inst_ready = tbl[i].ir;
            half();
            chk("t1_req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) chk("t1_req_addr", imem_req_addr, tbl[i].addr);
            chk("t1_inst_valid", 32'(inst_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) chk("t1_inst_pc", inst_pc, tbl[i].ipc);
            chk("t5_req_valid", 32'(d2_req_valid), 32'(i < 4));
            if (i < 4) chk("t5_req_addr", d2_req_addr, d2_addr[i]);
            tail();
        end
        chk("t5_inst_valid", 32'(d2_inst_valid), 32'h0);
        chk("t5_inst", d2_inst ^ d2_inst_pc, 32'h0);
        // decode stalled: credit limits fetches to DEPTH
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        repeat (8) step();
        chk("t2_accepts", n_acc, 32'd2);
        chk("t2_last_addr", last_acc, 32'h4);
        half();
        chk("t2_stalled", 32'(imem_req_valid), 32'h0);
        tail();
        inst_ready = 1'b1;
        wait_acc(10, found, pc);
        chk("t2_resume_found", 32'(found), 32'h1);
        chk("t2_resume_addr", pc, 32'h8);
        repeat (6) step();
        // redirect with two fetches in flight
        do_reset();
        lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        half();
        chk("t3_flushed", 32'(inst_valid), 32'h0);
        tail();
        wait_iv(20, found, pc);
        chk("t3_found", 32'(found), 32'h1);
        chk("t3_first_pc", pc, 32'h100);
        wait_iv(20, found, pc);
        chk("t3_second_pc", pc, 32'h104);
        // redirect coinciding with a response, misaligned target
        do_reset();
        lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        half();
        chk("t4_req_valid", 32'(imem_req_valid), 32'h1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        tail();
        wait_iv(20, found, pc);
        chk("t4_first_pc", pc, 32'h200);
        // back-to-back redirects: the last target wins
        do_reset();
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        wait_iv(20, found, pc);
        chk("t4b_first_pc", pc, 32'h400);
        // asynchronous reset with buffered entries
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        repeat (4) step();
        half();
        chk("t6_buffered", 32'(inst_valid), 32'h1);
        tail();
        do_reset();
        half();
        chk("t6_drop", 32'(dut.r_drop), 32'h0);
        chk("t6_restart_valid", 32'(imem_req_valid), 32'h1);
        chk("t6_restart_addr", imem_req_addr, RESET_PC);
        tail();
        inst_ready = 1'b1;
        wait_iv(20, found, pc);
        chk("t6_first_pc", pc, RESET_PC);
        // random traffic across latencies
        for (int l = 1; l <= 3; l++) begin
            lat = l;
            for (int i = 0; i < 150; i++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                inst_ready = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 19) == 0);
                redirect_pc = $urandom;
                step();
            end
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
